// File: rtl/dmem_responder.sv
// Doubleword data memory with a completion mailbox, a watchdog and
// sticky status flags.
module dmem_responder #(
  parameter int          DEPTH     = 32,
  parameter logic [63:0] MBOX_ADDR = 64'd80,
  parameter int          TIMEOUT   = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  memwrite,
  input  logic [63:0] dataadr,
  input  logic [63:0] writedata,
  output logic [63:0] readdata,
  input  logic [4:0]  checka,
  output logic [63:0] check,
  output logic        done,
  output logic [7:0]  code,
  output logic        timeout,
  output logic        err,
  output logic [9:0]  wrcount
);

  localparam int          IDXW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] BYTE_SPAN = 64'(DEPTH) * 64'd8;
  localparam int          WDW       = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  logic [63:0]     mem_q [DEPTH];
  logic [63:0]     entry_d;
  logic            done_q, done_d;
  logic [7:0]      code_q, code_d;
  logic            timeout_q, timeout_d;
  logic            err_q, err_d;
  logic [9:0]      wrcount_q, wrcount_d;
  logic [WDW-1:0]  wdCount_q, wdCount_d;

  logic [IDXW-1:0] adrIdx;
  logic [IDXW-1:0] checkIdx;
  logic            adrInRange;
  logic            checkInRange;
  logic            wordReq;
  logic            dwordReq;
  logic            aligned;
  logic            wrAccept;
  logic            wrReject;
  logic            mboxHit;
  logic            wdRun;

  // Address decode and write acceptance; in-range implies the index is below DEPTH.
  always_comb begin
    adrIdx       = dataadr[IDXW+2:3];
    checkIdx     = IDXW'(checka);
    adrInRange   = (dataadr < BYTE_SPAN);
    checkInRange = (32'(checka) < 32'(DEPTH));
    wordReq      = (memwrite == 2'b01);
    dwordReq     = (memwrite == 2'b10);
    aligned      = wordReq ? (dataadr[1:0] == 2'b00) : (dataadr[2:0] == 3'b000);
    wrAccept     = (wordReq || dwordReq) && adrInRange && aligned;
    wrReject     = (memwrite != 2'b00) && !wrAccept;
    mboxHit      = wrAccept && (dataadr == MBOX_ADDR);
  end

  always_comb begin
    entry_d = '0;
    if (wrAccept) begin
      if (dwordReq) begin
        entry_d = writedata;
      end else if (dataadr[2]) begin
        entry_d = {writedata[31:0], mem_q[adrIdx][31:0]};
      end else begin
        entry_d = {mem_q[adrIdx][63:32], writedata[31:0]};
      end
    end
  end

  always_comb begin
    readdata = adrInRange   ? mem_q[adrIdx]   : '0;
    check    = checkInRange ? mem_q[checkIdx] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wrAccept) begin
      mem_q[adrIdx] <= entry_d;
    end
  end

  // A mailbox write landing on the watchdog's final edge wins: done sets, timeout stays clear.
  always_comb begin
    wdRun     = !done_q && !timeout_q;
    done_d    = done_q | mboxHit;
    code_d    = (mboxHit && !done_q) ? writedata[7:0] : code_q;
    err_d     = err_q | wrReject;
    wrcount_d = (wrAccept && (wrcount_q != 10'h3FF)) ? wrcount_q + 10'd1 : wrcount_q;
    wdCount_d = wdRun ? wdCount_q + WDW'(1) : wdCount_q;
    timeout_d = timeout_q | (wdRun && (wdCount_q == WD_LAST) && !mboxHit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q    <= 1'b0;
      code_q    <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      wrcount_q <= '0;
      wdCount_q <= '0;
    end else begin
      done_q    <= done_d;
      code_q    <= code_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      wrcount_q <= wrcount_d;
      wdCount_q <= wdCount_d;
    end
  end

  assign done    = done_q;
  assign code    = code_q;
  assign timeout = timeout_q;
  assign err     = err_q;
  assign wrcount = wrcount_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: stimulus is applied just after the
// rising edge and every check samples the DUT outputs at the following negedge.
module tb_dmem_responder;

   localparam int SEL_RD   = 0;
   localparam int SEL_CHK  = 1;
   localparam int SEL_DONE = 2;
   localparam int SEL_CODE = 3;
   localparam int SEL_TMO  = 4;
   localparam int SEL_ERR  = 5;
   localparam int SEL_WRC  = 6;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  memwrite = 2'b00;
   logic [63:0] dataadr = '0;
   logic [63:0] writedata = '0;
   logic [4:0]  checka = '0;
   logic [63:0] readdata;
   logic [63:0] check;
   logic        done;
   logic [7:0]  code;
   logic        timeout;
   logic        err;
   logic [9:0]  wrcount;

   int          checks = 0;
   int          errors = 0;

   // Free-running clock with a 10 time-unit period.
   always #5 clk = ~clk;

   dmem_responder #(
      .DEPTH(32),
      .MBOX_ADDR(64'd80),
      .TIMEOUT(48)
   ) dut (
      .clk(clk),
      .reset(reset),
      .memwrite(memwrite),
      .dataadr(dataadr),
      .writedata(writedata),
      .readdata(readdata),
      .checka(checka),
      .check(check),
      .done(done),
      .code(code),
      .timeout(timeout),
      .err(err),
      .wrcount(wrcount)
   );

   // Move to the sampling negedge unless already sitting on one.
   task automatic toSample();
      if (($time % 10) != 0) begin
         @(negedge clk);
      end
   endtask

   // Book-keeping for one comparison result.
   task automatic note(input string name, input logic [63:0] act,
                       input logic [63:0] exp, input logic ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Drive one cycle of write-port inputs just after the rising edge.
   task automatic applyStimulus(input logic [1:0] mw, input logic [63:0] adr,
                                input logic [63:0] wd);
      @(posedge clk);
      #1;
      memwrite  = mw;
      dataadr   = adr;
      writedata = wd;
   endtask

   // Compare one selected DUT output at the sampling negedge.
   task automatic checkOutput(input string name, input int sel, input logic [63:0] exp);
      logic [63:0] act;
      logic        ok;
      toSample();
      act = '0;
      ok  = 1'b0;
      case (sel)
         SEL_RD: begin
            act = readdata;
            ok  = (readdata === exp);
         end
         SEL_CHK: begin
            act = check;
            ok  = (check === exp);
         end
         SEL_DONE: begin
            act = 64'(done);
            ok  = (64'(done) === exp);
         end
         SEL_CODE: begin
            act = 64'(code);
            ok  = (64'(code) === exp);
         end
         SEL_TMO: begin
            act = 64'(timeout);
            ok  = (64'(timeout) === exp);
         end
         SEL_ERR: begin
            act = 64'(err);
            ok  = (64'(err) === exp);
         end
         SEL_WRC: begin
            act = 64'(wrcount);
            ok  = (64'(wrcount) === exp);
         end
         default: begin
            act = '0;
            ok  = 1'b0;
         end
      endcase
      note(name, act, exp, ok);
   endtask

   // Compare all sticky status outputs and the write counter at once.
   task automatic checkStatus(input string tag, input logic d, input logic t,
                              input logic e, input logic [9:0] w);
      toSample();
      note({tag, ".done"}, 64'(done), 64'(d), done === d);
      note({tag, ".timeout"}, 64'(timeout), 64'(t), timeout === t);
      note({tag, ".err"}, 64'(err), 64'(e), err === e);
      note({tag, ".wrcount"}, 64'(wrcount), 64'(w), wrcount === w);
   endtask

   // Hold reset for one edge with the given write request present, then release.
   task automatic doReset(input logic [1:0] mw, input logic [63:0] adr,
                          input logic [63:0] wd);
      @(posedge clk);
      #1;
      reset     = 1'b1;
      memwrite  = mw;
      dataadr   = adr;
      writedata = wd;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      memwrite  = 2'b00;
      dataadr   = adr;
      writedata = '0;
   endtask

   // Idle cycles with no write request.
   task automatic idle(input int n, input logic [63:0] adr);
      repeat (n) applyStimulus(2'b00, adr, 64'd0);
   endtask

   // Global simulation watchdog.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got no finish, want finish");
      $fatal(1, "[TB] simulation time limit");
   end

   // Directed test sequence.
   initial begin
      doReset(2'b00, 64'd16, 64'd0);
      checkStatus("rst", 1'b0, 1'b0, 1'b0, 10'd0);
      checkOutput("rst.code", SEL_CODE, 64'd0);
      checkOutput("rst.readdata", SEL_RD, 64'd0);

      applyStimulus(2'b10, 64'd16, 64'h1122334455667788);
      checkOutput("dw.old_data", SEL_RD, 64'd0);
      applyStimulus(2'b00, 64'd16, 64'd0);
      checkOutput("dw.new_data", SEL_RD, 64'h1122334455667788);
      checkStatus("dw", 1'b0, 1'b0, 1'b0, 10'd1);

      applyStimulus(2'b01, 64'd20, 64'hFFFFFFFF_AABBCCDD);
      applyStimulus(2'b00, 64'd16, 64'd0);
      checka = 5'd2;
      checkOutput("wd_hi.readdata", SEL_RD, 64'hAABBCCDD55667788);
      checkOutput("wd_hi.check", SEL_CHK, 64'hAABBCCDD55667788);
      checkOutput("wd_hi.wrcount", SEL_WRC, 64'd2);

      applyStimulus(2'b01, 64'd22, 64'h12345678);
      checkOutput("misal.err_pending", SEL_ERR, 64'd0);
      applyStimulus(2'b00, 64'd16, 64'd0);
      checkOutput("misal.readdata", SEL_RD, 64'hAABBCCDD55667788);
      checkStatus("misal", 1'b0, 1'b0, 1'b1, 10'd2);

      applyStimulus(2'b01, 64'd16, 64'h0BADF00D);
      applyStimulus(2'b00, 64'd16, 64'd0);
      checkOutput("wd_lo.readdata", SEL_RD, 64'hAABBCCDD0BADF00D);
      checkOutput("wd_lo.wrcount", SEL_WRC, 64'd3);

      doReset(2'b00, 64'd256, 64'd0);
      applyStimulus(2'b10, 64'd256, 64'hDEADBEEF);
      applyStimulus(2'b00, 64'd256, 64'd0);
      checkOutput("oor.readdata", SEL_RD, 64'd0);
      checkStatus("oor", 1'b0, 1'b0, 1'b1, 10'd0);

      doReset(2'b00, 64'd0, 64'd0);
      applyStimulus(2'b11, 64'd0, 64'h55);
      applyStimulus(2'b00, 64'd0, 64'd0);
      checkOutput("rsvd.readdata", SEL_RD, 64'd0);
      checkStatus("rsvd", 1'b0, 1'b0, 1'b1, 10'd0);

      doReset(2'b00, 64'd8, 64'd0);
      applyStimulus(2'b10, 64'd12, 64'h77);
      applyStimulus(2'b00, 64'd8, 64'd0);
      checkOutput("dwmisal.readdata", SEL_RD, 64'd0);
      checkOutput("dwmisal.err", SEL_ERR, 64'd1);

      doReset(2'b00, 64'd248, 64'd0);
      applyStimulus(2'b10, 64'd248, 64'h0123456789ABCDEF);
      applyStimulus(2'b00, 64'd248, 64'd0);
      checka = 5'd31;
      checkOutput("top.readdata", SEL_RD, 64'h0123456789ABCDEF);
      checkOutput("top.check", SEL_CHK, 64'h0123456789ABCDEF);
      checkStatus("top", 1'b0, 1'b0, 1'b0, 10'd1);

      doReset(2'b00, 64'd80, 64'd0);
      idle(9, 64'd80);
      applyStimulus(2'b01, 64'd80, 64'hFFFFFF07);
      checkOutput("mbox.done_pending", SEL_DONE, 64'd0);
      applyStimulus(2'b00, 64'd80, 64'd0);
      checkOutput("mbox.done", SEL_DONE, 64'd1);
      checkOutput("mbox.code", SEL_CODE, 64'h07);
      checkOutput("mbox.readdata", SEL_RD, 64'h00000000FFFFFF07);
      applyStimulus(2'b01, 64'd80, 64'h99);
      applyStimulus(2'b00, 64'd80, 64'd0);
      checkOutput("mbox2.code", SEL_CODE, 64'h07);
      checkOutput("mbox2.readdata", SEL_RD, 64'h99);
      checkOutput("mbox2.wrcount", SEL_WRC, 64'd2);
      idle(95, 64'd80);
      checkStatus("mbox_late", 1'b1, 1'b0, 1'b0, 10'd2);

      doReset(2'b00, 64'd0, 64'd0);
      idle(47, 64'd0);
      checkOutput("wd.cycle47", SEL_TMO, 64'd0);
      idle(1, 64'd0);
      checkOutput("wd.cycle48", SEL_TMO, 64'd1);
      idle(5, 64'd0);
      checkStatus("wd.hold", 1'b0, 1'b1, 1'b0, 10'd0);

      doReset(2'b00, 64'd80, 64'd0);
      idle(46, 64'd80);
      applyStimulus(2'b01, 64'd80, 64'h42);
      checkOutput("race.tmo_before", SEL_TMO, 64'd0);
      applyStimulus(2'b00, 64'd80, 64'd0);
      checkStatus("race", 1'b1, 1'b0, 1'b0, 10'd1);
      checkOutput("race.code", SEL_CODE, 64'h42);
      checkOutput("race.readdata", SEL_RD, 64'h42);
      idle(5, 64'd80);
      checkOutput("race.tmo_hold", SEL_TMO, 64'd0);
      checka = 5'd10;
      doReset(2'b10, 64'd0, 64'hCAFE);
      checkStatus("rst2", 1'b0, 1'b0, 1'b0, 10'd0);
      checkOutput("rst2.code", SEL_CODE, 64'd0);
      checkOutput("rst2.entry0", SEL_RD, 64'd0);
      checkOutput("rst2.mbox_entry", SEL_CHK, 64'd0);

      doReset(2'b00, 64'd0, 64'd0);
      for (int i = 0; i < 1030; i++) begin
         applyStimulus(2'b10, 64'd0, 64'(i));
      end
      applyStimulus(2'b00, 64'd0, 64'd0);
      checkOutput("sat.wrcount", SEL_WRC, 64'd1023);
      checkOutput("sat.readdata", SEL_RD, 64'd1029);
      checkOutput("sat.err", SEL_ERR, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
